// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared widths, port enum, aging limit and {port,id} helper for the ENIGMA arbiter
package enigma_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int ID_W_DEF   = 5;
    localparam int QOS_W_DEF  = 2;
    localparam int AGE_W      = 4;

    localparam logic [AGE_W-1:0] AGE_MAX_DEF = 4'd15;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Scoreboard index: the source port is the MSB so both ports share one table.
    function automatic logic [ID_W_DEF:0] port_id(input port_e p, input logic [ID_W_DEF-1:0] id);
        return {p, id};
    endfunction

endpackage

// File: rtl/enigma_arb_sb.sv
// rtl/enigma_arb_sb.sv - outstanding {port,id} scoreboard: one set, one clear, two combinational lookups
module enigma_arb_sb #(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] look_a_idx,
    input  logic [IDX_W-1:0] look_b_idx,
    output logic             hit_a,
    output logic             hit_b
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] sb;

    // Set is written last so it wins; a same-index clear can only hit an already-zero bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            if (clr_en) sb[clr_idx] <= 1'b0;
            if (set_en) sb[set_idx] <= 1'b1;
        end
    end

    assign hit_a = sb[look_a_idx];
    assign hit_b = sb[look_b_idx];

endmodule

// File: rtl/enigma_arb.sv
// rtl/enigma_arb.sv - ENIGMA port C QoS arbiter with aging and outstanding-id blocking
// Optional per-port grant counters when ENIGMA_ARB_STATS_EN is defined.
module enigma_arb
    import enigma_pkg::*;
#(
    parameter int               DATA_W  = DATA_W_DEF,
    parameter int               ID_W    = ID_W_DEF,
    parameter int               QOS_W   = QOS_W_DEF,
    parameter logic [AGE_W-1:0] AGE_MAX = AGE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] payload_a,
    input  logic [ID_W-1:0]   id_a,
    input  logic [QOS_W-1:0]  qos_a,
    input  logic              valid_a,
    output logic              ready_a,
    input  logic [DATA_W-1:0] payload_b,
    input  logic [ID_W-1:0]   id_b,
    input  logic [QOS_W-1:0]  qos_b,
    input  logic              valid_b,
    output logic              ready_b,
    input  logic              conflict_c,
    input  logic              release_c,
    input  logic [ID_W:0]     releaseid_c,
    input  logic              ready_c,
    output logic              valid_c,
    output logic [DATA_W-1:0] payload_c,
    output logic [ID_W:0]     id_c,
    output logic [QOS_W-1:0]  qos_c
`ifdef ENIGMA_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_grant_a,
    output logic [15:0]       stat_grant_b
`endif
);

    logic [ID_W:0]      idx_a;
    logic [ID_W:0]      idx_b;
    logic               hit_a;
    logic               hit_b;
    logic               elig_a;
    logic               elig_b;
    logic               accept_c;
    logic               load_en;
    logic               sel_b;
    logic               grant_a;
    logic               grant_b;
    port_e              rr_ptr;
    logic [AGE_W-1:0]   age_a;
    logic [AGE_W-1:0]   age_b;

    assign idx_a = port_id(PORT_A, id_a);
    assign idx_b = port_id(PORT_B, id_b);

    enigma_arb_sb #(
        .IDX_W (ID_W + 1)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (grant_a | grant_b),
        .set_idx    (grant_b ? idx_b : idx_a),
        .clr_en     (release_c),
        .clr_idx    (releaseid_c),
        .look_a_idx (idx_a),
        .look_b_idx (idx_b),
        .hit_a      (hit_a),
        .hit_b      (hit_b)
    );

    assign elig_a   = valid_a & ~hit_a;
    assign elig_b   = valid_b & ~hit_b;
    assign accept_c = valid_c & ready_c & ~conflict_c;
    assign load_en  = ~valid_c | accept_c;

    // Starvation override first, then qos, then round-robin.
    always_comb begin
        sel_b = 1'b0;
        if (elig_a && elig_b) begin
            if (age_a == AGE_MAX && age_b == AGE_MAX) sel_b = (rr_ptr == PORT_B);
            else if (age_a == AGE_MAX)                sel_b = 1'b0;
            else if (age_b == AGE_MAX)                sel_b = 1'b1;
            else if (qos_a > qos_b)                   sel_b = 1'b0;
            else if (qos_b > qos_a)                   sel_b = 1'b1;
            else                                      sel_b = (rr_ptr == PORT_B);
        end else begin
            sel_b = elig_b;
        end
    end

    assign grant_a = rst_n & load_en & elig_a & ~sel_b;
    assign grant_b = rst_n & load_en & elig_b &  sel_b;
    assign ready_a = grant_a;
    assign ready_b = grant_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_c   <= 1'b0;
            payload_c <= '0;
            id_c      <= '0;
            qos_c     <= '0;
            rr_ptr    <= PORT_A;
        end else if (load_en) begin
            if (grant_a) begin
                valid_c   <= 1'b1;
                payload_c <= payload_a;
                id_c      <= idx_a;
                qos_c     <= qos_a;
                rr_ptr    <= PORT_B;
            end else if (grant_b) begin
                valid_c   <= 1'b1;
                payload_c <= payload_b;
                id_c      <= idx_b;
                qos_c     <= qos_b;
                rr_ptr    <= PORT_A;
            end else begin
                valid_c   <= 1'b0;
            end
        end
    end

    // An age only advances on cycles where the slot was actually up for grabs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_a <= '0;
            age_b <= '0;
        end else begin
            if (grant_a || !elig_a)              age_a <= '0;
            else if (load_en && age_a != AGE_MAX) age_a <= age_a + 1'b1;

            if (grant_b || !elig_b)              age_b <= '0;
            else if (load_en && age_b != AGE_MAX) age_b <= age_b + 1'b1;
        end
    end

`ifdef ENIGMA_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_grant_a <= '0;
            stat_grant_b <= '0;
        end else begin
            if (grant_a && stat_grant_a != 16'hFFFF) stat_grant_a <= stat_grant_a + 16'd1;
            if (grant_b && stat_grant_b != 16'hFFFF) stat_grant_b <= stat_grant_b + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_enigma_arb.sv
// tb/tb_enigma_arb.sv - directed self-checking bench for enigma_arb with an output scoreboard queue
module tb_enigma_arb;

    localparam int DW = 128;
    localparam int IW = 5;
    localparam int QW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] payload_a, payload_b;
    logic [IW-1:0] id_a, id_b;
    logic [QW-1:0] qos_a, qos_b;
    logic          valid_a, valid_b;
    logic          ready_a, ready_b;
    logic          conflict_c, release_c, ready_c;
    logic [IW:0]   releaseid_c;
    logic          valid_c;
    logic [DW-1:0] payload_c;
    logic [IW:0]   id_c;
    logic [QW-1:0] qos_c;
`ifdef ENIGMA_ARB_STATS_EN
    logic          stat_clr = 1'b0;
    logic [15:0]   stat_grant_a, stat_grant_b;
`endif

    always #5 clk = ~clk;

    enigma_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .payload_a   (payload_a),
        .id_a        (id_a),
        .qos_a       (qos_a),
        .valid_a     (valid_a),
        .ready_a     (ready_a),
        .payload_b   (payload_b),
        .id_b        (id_b),
        .qos_b       (qos_b),
        .valid_b     (valid_b),
        .ready_b     (ready_b),
        .conflict_c  (conflict_c),
        .release_c   (release_c),
        .releaseid_c (releaseid_c),
        .ready_c     (ready_c),
        .valid_c     (valid_c),
        .payload_c   (payload_c),
        .id_c        (id_c),
        .qos_c       (qos_c)
`ifdef ENIGMA_ARB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_grant_a (stat_grant_a),
        .stat_grant_b (stat_grant_b)
`endif
    );

    typedef struct {
        logic [IW:0]   id;
        logic [DW-1:0] pl;
        logic [QW-1:0] qos;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endfunction

    function automatic logic [DW-1:0] pl_of(input logic port, input logic [IW-1:0] id);
        logic [7:0] tag;
        tag = port ? 8'hBB : 8'hAA;
        return {tag, 115'h0, id};
    endfunction

    function automatic void push(input logic port, input logic [IW-1:0] id, input logic [QW-1:0] q);
        exp_t e;
        e.id  = {port, id};
        e.pl  = pl_of(port, id);
        e.qos = q;
        exp_q.push_back(e);
    endfunction

    task automatic drive_a(input logic v, input logic [IW-1:0] id, input logic [QW-1:0] q);
        valid_a = v; id_a = id; qos_a = q; payload_a = pl_of(1'b0, id);
    endtask

    task automatic drive_b(input logic v, input logic [IW-1:0] id, input logic [QW-1:0] q);
        valid_b = v; id_b = id; qos_b = q; payload_b = pl_of(1'b1, id);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic ea, input logic eb);
        @(negedge clk);
        check({tag, "_ready_a"}, DW'(ready_a), DW'(ea));
        check({tag, "_ready_b"}, DW'(ready_b), DW'(eb));
    endtask

    task automatic idle_inputs();
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        release_c = 1'b0; releaseid_c = '0; conflict_c = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        next();
        next();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        idle_inputs();
        ready_c = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) next();
        check({tag, "_drained"}, DW'(exp_q.size()), '0);
    endtask

    // Every accepted output beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && valid_c && ready_c && !conflict_c) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_out: id_c %0h accepted with nothing expected", id_c);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("out_id",      DW'(id_c),  DW'(mon_e.id));
                check("out_payload", payload_c,  mon_e.pl);
                check("out_qos",     DW'(qos_c), DW'(mon_e.qos));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        ready_c = 1'b0;
        rst_n   = 1'b0;
        drive_a(1'b1, 5'd1, 2'd3);
        next();
        next();
        @(negedge clk);
        check("rst_valid_c",   DW'(valid_c), '0);
        check("rst_payload_c", payload_c,    '0);
        check("rst_id_c",      DW'(id_c),    '0);
        check("rst_qos_c",     DW'(qos_c),   '0);
        check("rst_ready_a",   DW'(ready_a), '0);
        next();
        rst_n = 1'b1;

        // 1: qos priority, then the loser follows
        drive_a(1'b1, 5'd1, 2'd3); drive_b(1'b1, 5'd2, 2'd1); ready_c = 1'b1;
        push(1'b0, 5'd1, 2'd3);
        chk_ready("t1_c0", 1'b1, 1'b0);
        next();
        drive_a(1'b0, '0, '0);
        push(1'b1, 5'd2, 2'd1);
        chk_ready("t1_c1", 1'b0, 1'b1);
        next();
        drive_b(1'b0, '0, '0);
        chk_ready("t1_c2", 1'b0, 1'b0);
        next();
        drain("t1");
        do_reset();

        // 2: equal qos round-robin, A first after reset
        ready_c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, 5'(i), 2'd2);
            drive_b(1'b1, 5'(i + 8), 2'd2);
            if (i % 2 == 0) push(1'b0, 5'(i), 2'd2);
            else            push(1'b1, 5'(i + 8), 2'd2);
            chk_ready($sformatf("t2_c%0d", i), (i % 2 == 0), (i % 2 == 1));
            next();
        end
        drain("t2");
        do_reset();

        // 3: aging forces the low-qos port on grant 16
        ready_c = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_a(1'b1, 5'(i), 2'd3);
            drive_b(1'b1, 5'd7, 2'd0);
            if (i == 15) push(1'b1, 5'd7, 2'd0);
            else         push(1'b0, 5'(i), 2'd3);
            chk_ready($sformatf("t3_c%0d", i), (i != 15), (i == 15));
            next();
        end
        drain("t3");
        do_reset();

        // 4: duplicate id blocked until its release; stray release ignored
        ready_c = 1'b1;
        drive_a(1'b1, 5'd5, 2'd1);
        push(1'b0, 5'd5, 2'd1);
        chk_ready("t4_c0", 1'b1, 1'b0);
        next();
        for (int i = 1; i < 4; i++) begin
            release_c   = (i == 1);
            releaseid_c = 6'h25;
            chk_ready($sformatf("t4_c%0d", i), 1'b0, 1'b0);
            next();
        end
        release_c = 1'b1; releaseid_c = 6'h05;
        chk_ready("t4_rel", 1'b0, 1'b0);
        next();
        release_c = 1'b0;
        push(1'b0, 5'd5, 2'd1);
        chk_ready("t4_regrant", 1'b1, 1'b0);
        next();
        drain("t4");
        do_reset();

        // 5: conflict holds the slot for 3 cycles
        ready_c = 1'b1; conflict_c = 1'b1;
        drive_a(1'b1, 5'd3, 2'd1);
        push(1'b0, 5'd3, 2'd1);
        chk_ready("t5_c0", 1'b1, 1'b0);
        next();
        for (int i = 1; i < 4; i++) begin
            drive_a(1'b1, 5'd4, 2'd1);
            drive_b(1'b1, 5'd9, 2'd1);
            chk_ready($sformatf("t5_c%0d", i), 1'b0, 1'b0);
            check($sformatf("t5_valid_c%0d", i),   DW'(valid_c), DW'(1'b1));
            check($sformatf("t5_id_c%0d", i),      DW'(id_c),    DW'(6'h03));
            check($sformatf("t5_payload_c%0d", i), payload_c,    pl_of(1'b0, 5'd3));
            next();
        end
        conflict_c = 1'b0;
        push(1'b1, 5'd9, 2'd1);
        chk_ready("t5_c4", 1'b0, 1'b1);
        next();
        drive_b(1'b0, '0, '0);
        push(1'b0, 5'd4, 2'd1);
        chk_ready("t5_c5", 1'b1, 1'b0);
        next();
        drain("t5");
        do_reset();

        // 6: reset drops the slot and all outstanding ids
        ready_c = 1'b1;
        drive_a(1'b1, 5'd1, 2'd0);
        push(1'b0, 5'd1, 2'd0);
        chk_ready("t6_c0", 1'b1, 1'b0);
        next();
        drive_a(1'b0, '0, '0); drive_b(1'b1, 5'd2, 2'd0);
        push(1'b1, 5'd2, 2'd0);
        chk_ready("t6_c1", 1'b0, 1'b1);
        next();
        drive_b(1'b0, '0, '0); drive_a(1'b1, 5'd3, 2'd0);
        chk_ready("t6_c2", 1'b1, 1'b0);
        next();
        ready_c = 1'b0;
        drive_a(1'b1, 5'd1, 2'd0);
        chk_ready("t6_blocked", 1'b0, 1'b0);
        check("t6_slot_full", DW'(valid_c), DW'(1'b1));
        next();
        rst_n = 1'b0;
        chk_ready("t6_in_rst", 1'b0, 1'b0);
        next();
        rst_n = 1'b1; ready_c = 1'b1;
        exp_q.delete();
        push(1'b0, 5'd1, 2'd0);
        chk_ready("t6_after_rst", 1'b1, 1'b0);
        check("t6_valid_c_cleared", DW'(valid_c), '0);
        next();
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
